// File: rtl/stopwatch_core_pkg.sv
// Shared stopwatch types and constants: FSM encoding, seconds wrap limit, BCD digit width.
package stopwatch_core_pkg;

    localparam int DIGIT_W   = 4;
    localparam int LIMIT_W   = 7;
    localparam int SEC_LIMIT = 59;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_core_mod60.sv
// Two-digit BCD counter wrapping to 00 after a programmable limit; one-cycle update on inc.
// carry is combinational: high when inc arrives while the count sits at the limit.
module mod60_bcd_counter
    import stopwatch_core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic [LIMIT_W-1:0] limit,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    logic [LIMIT_W-1:0] value;
    logic               at_limit;

    always_comb begin
        value    = LIMIT_W'(tens) * LIMIT_W'(10) + LIMIT_W'(ones);
        at_limit = (value == limit);
        carry    = inc && at_limit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == DIGIT_W'(9)) begin
                ones <= '0;
                tens <= tens + DIGIT_W'(1);
            end else begin
                ones <= ones + DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause/adjust FSM; digits update on the edge that samples a tick input high.
// No backpressure: inputs are level/pulse signals sampled every master_clock cycle.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic               master_clock,
    input  logic               rst,
    input  logic               clock1hz,
    input  logic               clock2hz,
    input  logic               clock_adjust,
    input  logic               pause,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               blank_min,
    output logic               blank_sec
);

    localparam logic [LIMIT_W-1:0] SEC_LIM = LIMIT_W'(SEC_LIMIT);
    localparam logic [LIMIT_W-1:0] MIN_LIM = LIMIT_W'(MIN_LIMIT);

    state_t state;
    logic   c1hz_q;
    logic   cadj_q;
    logic   tick_1hz;
    logic   tick_adj;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_carry;
    logic   min_carry;

    // Previous samples reset high so a level already high at release is not a rise.
    always_ff @(posedge master_clock or posedge rst) begin
        if (rst) begin
            c1hz_q <= 1'b1;
            cadj_q <= 1'b1;
        end else begin
            c1hz_q <= clock1hz;
            cadj_q <= clock_adjust;
        end
    end

    assign tick_1hz = clock1hz & ~c1hz_q;
    assign tick_adj = clock_adjust & ~cadj_q;

    // Increments follow the pre-transition state; adjust never carries between fields.
    assign sec_inc = ((state == ST_RUN) && tick_1hz) ||
                     ((state == ST_ADJUST) && tick_adj && !sel);
    assign min_inc = ((state == ST_RUN) && sec_carry) ||
                     ((state == ST_ADJUST) && tick_adj && sel);

    mod60_bcd_counter u_sec (
        .clk   (master_clock),
        .rst   (rst),
        .inc   (sec_inc),
        .limit (SEC_LIM),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    mod60_bcd_counter u_min (
        .clk   (master_clock),
        .rst   (rst),
        .inc   (min_inc),
        .limit (MIN_LIM),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    // adj high keeps or enters ADJUST from every state, so it also qualifies the blank registers.
    always_ff @(posedge master_clock or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (adj)        state <= ST_ADJUST;
                    else if (pause) state <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (adj)        state <= ST_ADJUST;
                    else if (pause) state <= ST_RUN;
                end
                ST_ADJUST: begin
                    if (!adj)       state <= ST_PAUSED;
                end
                default:            state <= ST_RUN;
            endcase
            blank_min <= adj && sel && clock2hz;
            blank_sec <= adj && !sel && clock2hz;
        end
    end

    // A minute wrap while running always lands the whole display on 00:00.
    assert property (@(posedge master_clock) disable iff (rst)
        (min_carry && state == ST_RUN) |=>
        (min_tens == '0 && min_ones == '0 && sec_tens == '0 && sec_ones == '0));

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboarded bench: stimulus pushes expected display from a total-seconds model, monitor compares.
module tb_stopwatch_core;

    localparam int MIN_LIMIT = 59;
    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_ADJUST = 2;

    logic       master_clock = 1'b1;
    logic       rst          = 1'b0;
    logic       clock1hz     = 1'b0;
    logic       clock2hz     = 1'b0;
    logic       clock_adjust = 1'b0;
    logic       pause        = 1'b0;
    logic       adj          = 1'b0;
    logic       sel          = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec;

    typedef struct {
        int    mt, mo, st, so;
        bit    bm, bs;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    string cur_tag     = "reset";

    int m_min   = 0;
    int m_sec   = 0;
    int m_state = M_RUN;
    bit p1      = 1'b1;
    bit pa      = 1'b1;

    always #5 master_clock = ~master_clock;

    stopwatch_core #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .master_clock (master_clock),
        .rst          (rst),
        .clock1hz     (clock1hz),
        .clock2hz     (clock2hz),
        .clock_adjust (clock_adjust),
        .pause        (pause),
        .adj          (adj),
        .sel          (sel),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .blank_min    (blank_min),
        .blank_sec    (blank_sec)
    );

    function automatic exp_t make_exp(bit bm, bit bs, string tag);
        exp_t e;
        e.mt  = m_min / 10;
        e.mo  = m_min % 10;
        e.st  = m_sec / 10;
        e.so  = m_sec % 10;
        e.bm  = bm;
        e.bs  = bs;
        e.tag = tag;
        return e;
    endfunction

    // Model of one master_clock edge with the inputs currently driven.
    task automatic step();
        bit t1, ta, bm, bs;
        int total;
        bm = 1'b0;
        bs = 1'b0;
        if (rst) begin
            m_min = 0; m_sec = 0; m_state = M_RUN; p1 = 1'b1; pa = 1'b1;
        end else begin
            t1 = clock1hz && !p1;
            ta = clock_adjust && !pa;
            if (m_state == M_RUN && t1) begin
                total = (m_min * 60 + m_sec + 1) % ((MIN_LIMIT + 1) * 60);
                m_min = total / 60;
                m_sec = total % 60;
            end else if (m_state == M_ADJUST && ta) begin
                if (sel) m_min = (m_min + 1) % (MIN_LIMIT + 1);
                else     m_sec = (m_sec + 1) % 60;
            end
            case (m_state)
                M_RUN:    m_state = adj ? M_ADJUST : (pause ? M_PAUSED : M_RUN);
                M_PAUSED: m_state = adj ? M_ADJUST : (pause ? M_RUN : M_PAUSED);
                default:  m_state = adj ? M_ADJUST : M_PAUSED;
            endcase
            p1 = clock1hz;
            pa = clock_adjust;
            bm = (m_state == M_ADJUST) && clock2hz && sel;
            bs = (m_state == M_ADJUST) && clock2hz && !sel;
        end
        exp_q.push_back(make_exp(bm, bs, cur_tag));
        @(negedge master_clock);
    endtask

    // Asserting reset must clear the display before the next clock edge.
    task automatic set_rst(bit v);
        if (v && !rst) begin
            m_min = 0; m_sec = 0; m_state = M_RUN; p1 = 1'b1; pa = 1'b1;
            exp_q.push_back(make_exp(1'b0, 1'b0, "rst_immediate"));
        end
        rst = v;
    endtask

    task automatic do_reset();
        set_rst(1'b1);
        step();
        step();
        set_rst(1'b0);
    endtask

    task automatic tick1();
        clock1hz = 1'b1; step(); step();
        clock1hz = 1'b0; step(); step();
    endtask

    task automatic tick_adj();
        clock2hz = ~clock2hz;
        clock_adjust = 1'b1; step();
        clock2hz = ~clock2hz;
        clock_adjust = 1'b0; step();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step();
        pause = 1'b0;
    endtask

    // Leaves the FSM in ADJUST holding m:s; caller decides how to leave.
    task automatic preload(int m, int s);
        adj = 1'b1; step();
        sel = 1'b0;
        for (int i = 0; i < 60 && m_sec != s; i++) tick_adj();
        sel = 1'b1;
        for (int i = 0; i <= MIN_LIMIT && m_min != m; i++) tick_adj();
    endtask

    task automatic preload_and_run(int m, int s);
        preload(m, s);
        adj = 1'b0; step();
        pulse_pause();
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge master_clock or posedge rst);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expectation: output seen with empty scoreboard at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (min_tens !== 4'(e.mt) || min_ones !== 4'(e.mo) ||
                    sec_tens !== 4'(e.st) || sec_ones !== 4'(e.so) ||
                    blank_min !== e.bm || blank_sec !== e.bs) begin
                    miscompares++;
                    $display("FAIL %s: got %0d%0d:%0d%0d bm=%0b bs=%0b, want %0d%0d:%0d%0d bm=%0b bs=%0b at %0t",
                             e.tag, min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec,
                             e.mt, e.mo, e.st, e.so, e.bm, e.bs, $time);
                end
            end
        end
    end

    initial begin : stimulus
        @(negedge master_clock);
        cur_tag = "reset";
        do_reset();
        step();

        cur_tag = "run_3s";
        for (int i = 0; i < 3; i++) tick1();

        cur_tag = "carry_00_59";
        preload_and_run(0, 59);
        tick1();

        cur_tag = "wrap_full";
        preload_and_run(MIN_LIMIT, 59);
        tick1();

        cur_tag = "pause_hold";
        preload_and_run(0, 5);
        pulse_pause();
        for (int i = 0; i < 4; i++) tick1();
        pulse_pause();
        tick1();

        cur_tag = "adjust_sec";
        preload(0, 58);
        sel = 1'b0;
        for (int i = 0; i < 3; i++) tick_adj();
        tick1();
        adj = 1'b0; step();
        tick1();

        cur_tag = "pause_with_tick";
        pulse_pause();
        preload_and_run(0, 10);
        pause = 1'b1; clock1hz = 1'b1; step();
        pause = 1'b0; step();
        clock1hz = 1'b0; step(); step();
        tick1();

        cur_tag = "adj_with_tick";
        pulse_pause();
        adj = 1'b1; clock1hz = 1'b1; step();
        clock1hz = 1'b0; step();
        tick1();
        adj = 1'b0; step();

        cur_tag = "reset_in_adjust";
        preload(12, 34);
        clock1hz = 1'b1;
        do_reset();
        adj = 1'b0;
        step(); step();
        clock1hz = 1'b0; step();
        tick1();

        cur_tag = "random";
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0)   clock1hz     = ~clock1hz;
            if ($urandom_range(1) == 0)   clock2hz     = ~clock2hz;
            if ($urandom_range(3) == 0)   clock_adjust = ~clock_adjust;
            if ($urandom_range(39) == 0)  adj          = ~adj;
            if ($urandom_range(9) == 0)   sel          = ~sel;
            pause = ($urandom_range(15) == 0);
            set_rst($urandom_range(599) == 0);
            step();
        end
        set_rst(1'b0);
        pause = 1'b0;
        step();

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MIN_LIMIT, default 59: highest minutes value before minutes wrap to 0.
REQ-002 master_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 clock1hz  in  1  1 Hz square wave from the clock divider, synchronous to master_clock; count source.
REQ-005 clock2hz  in  1  2 Hz square wave from the clock divider; blink source.
REQ-006 clock_adjust  in  1  adjust-rate square wave from the clock divider; adjust-increment source.
REQ-007 pause  in  1  single-cycle debounced pulse; toggles run/pause.
REQ-008 adj  in  1  level; high = adjust mode.
REQ-009 sel  in  1  level; 0 = adjust seconds, 1 = adjust minutes.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time digits, registered.
REQ-011 blank_min, blank_sec  out  1 each  display blank request for the adjusted field, registered.

Function
REQ-012 Rising-edge tick on a clock input SHALL be asserted in a master_clock cycle when the current sample is 1 and the previous registered sample is 0; one tick per input period.
REQ-013 FSM states: RUN, PAUSED, ADJUST.
REQ-014 RUN: on clock1hz tick, seconds +1; at 59, seconds -> 0 and minutes +1; at minutes MIN_LIMIT and seconds 59, both -> 0.
REQ-015 PAUSED: digits hold; all ticks ignored.
REQ-016 pause pulse in RUN -> PAUSED; in PAUSED -> RUN; ignored in ADJUST.
REQ-017 adj high in RUN or PAUSED -> ADJUST on next edge; adj low in ADJUST -> PAUSED on next edge.
REQ-018 ADJUST: on clock_adjust tick, the field chosen by sel increments by 1, wrapping 59->0 (seconds) or MIN_LIMIT->0 (minutes), with no carry into the other field; clock1hz ticks ignored.
REQ-019 Digit outputs SHALL change on the same master_clock edge that samples the tick-causing input high (one-cycle latency from input rise).
REQ-020 Simultaneous pause pulse and clock1hz tick: the tick is applied per the pre-transition state (RUN counts, then pauses).
REQ-021 Simultaneous adj rise and clock1hz tick in RUN: the tick counts; ADJUST takes effect the next cycle.
REQ-022 blank_min/blank_sec: in ADJUST, the field selected by sel blanks when the registered clock2hz sample is 1; otherwise both 0.
REQ-023 sel change in ADJUST takes effect the next tick; no digit change.
REQ-024 All digit values SHALL remain valid BCD (tens 0-5, ones 0-9) at all times.

Reset
REQ-025 rst high SHALL immediately force all digits 0, blank outputs 0, state RUN.
REQ-026 Previous-sample registers reset to 1 so no tick occurs on the first cycle after release.
REQ-027 rst mid-count or mid-adjust SHALL discard all progress; no pending tick survives.

Structure
REQ-028 Shared package holds the FSM state encoding, SEC_LIMIT=59 and the BCD digit width constant.
REQ-029 One sub-module, mod60_bcd_counter (inc, wrap-limit input, BCD tens/ones out, carry out), instanced for seconds and minutes.

Verification
REQ-030 Reset, run 3 clock1hz periods -> 00:03, changing one cycle after each clock1hz rise.
REQ-031 Preload 00:59 via adjust, run 1 tick -> 01:00; preload MIN_LIMIT:59, 1 tick -> 00:00.
REQ-032 At 00:05 pulse pause, apply 4 clock1hz periods -> holds 00:05; pause again, 1 tick -> 00:06.
REQ-033 adj=1, sel=0 at 00:58, 3 clock_adjust ticks -> 00:01, minutes unchanged; blank_sec toggles with clock2hz, blank_min stays 0; adj=0 -> PAUSED.
REQ-034 pause pulse coincident with clock1hz tick at 00:10 -> 00:11 then PAUSED.
REQ-035 Assert rst at 12:34 while adjusting -> 00:00 immediately, RUN, no tick on first cycle after release with clock1hz held high.
